// File: rtl/agu_rd.sv
// agu_rd: read-side responder for the address generation unit.
// Starts and throttles an AGU, issues reads to a synchronous memory with RL-cycle latency,
// and returns the read data as a valid/ready stream marked with last.
// Optional feature: define AGU_RD_BEAT_CNT_EN to count delivered beats on beat_cnt_o;
// when it is undefined, beat_cnt_o is tied to zero.
module agu_rd #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned RL    = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  output logic          agu_start_o,
  output logic          agu_en_o,
  input  logic [AW-1:0] agu_data_i,
  input  logic          agu_last_i,
  output logic          mem_en_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          m_valid_o,
  output logic [DW-1:0] m_data_o,
  output logic          m_last_o,
  input  logic          m_ready_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] beat_cnt_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + RL + 1) + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e            state_q;
  logic [RL-1:0]     pipe_vld_q;
  logic [RL-1:0]     pipe_last_q;
  logic [PtrW-1:0]   wptr_q;
  logic [PtrW-1:0]   rptr_q;
  logic [PtrW:0]     count_q;
  logic [DW-1:0]     fifo_data_q [DEPTH];
  logic [DEPTH-1:0]  fifo_last_q;

  logic [CntW-1:0]   inflight;
  logic [CntW-1:0]   occupancy;
  logic              issue_ok;
  logic              start_acc;
  logic              push;
  logic              push_last;
  logic              pop;
  logic              full;

  // Credit: reads in the pipeline plus FIFO occupancy, from registered state only.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RL; i++) begin
      inflight = inflight + CntW'(pipe_vld_q[i]);
    end
    occupancy = CntW'(count_q) + inflight;
    issue_ok  = occupancy < CntW'(DEPTH);
  end

  // Handshake towards the AGU, memory and stream.
  always_comb begin
    start_acc   = (state_q == StIdle) && start_i;
    agu_start_o = start_acc;
    agu_en_o    = issue_ok && (start_acc || (state_q == StIssue));
    mem_en_o    = agu_en_o;
    mem_addr_o  = agu_data_i;
    push        = pipe_vld_q[RL-1];
    push_last   = pipe_last_q[RL-1];
    full        = count_q == (PtrW+1)'(DEPTH);
    m_valid_o   = count_q != '0;
    m_data_o    = fifo_data_q[rptr_q];
    // Storage is not reset, so gate last with valid to keep it low while empty.
    m_last_o    = fifo_last_q[rptr_q] && m_valid_o;
    pop         = m_valid_o && m_ready_i;
    done_o      = (state_q == StDrain) && pop && m_last_o;
    busy_o      = state_q != StIdle;
  end

  // Control FSM. A single-beat block issues its only read in the start cycle, so it
  // passes through the issue phase within that cycle and lands directly in drain;
  // staying in issue would request a second, duplicate read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (start_i) state_q <= (agu_en_o && agu_last_i) ? StDrain : StIssue;
        StIssue: if (agu_en_o && agu_last_i) state_q <= StDrain;
        StDrain: if (done_o) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read pipeline: {valid, last} shift matching the memory latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      pipe_vld_q[0]  <= agu_en_o;
      pipe_last_q[0] <= agu_en_o && agu_last_i;
      for (int unsigned i = 1; i < RL; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + (PtrW+1)'(1);
      end else if (!push && pop) begin
        count_q <= count_q - (PtrW+1)'(1);
      end
    end
  end

  // FIFO storage; contents are only observed behind m_valid_o.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wptr_q] <= mem_rdata_i;
      fifo_last_q[wptr_q] <= push_last;
    end
  end

  // The credit scheme must make overflow impossible.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full))
    else $error("agu_rd: push into full FIFO");

`ifdef AGU_RD_BEAT_CNT_EN
  logic [AW-1:0] beat_cnt_q;

  // Delivered-beat counter, cleared by an accepted start and held after done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q <= '0;
    end else if (start_acc) begin
      beat_cnt_q <= '0;
    end else if (pop) begin
      beat_cnt_q <= beat_cnt_q + AW'(1);
    end
  end

  assign beat_cnt_o = beat_cnt_q;
`else
  assign beat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_agu_rd.sv
// Testbench for agu_rd: behavioural AGU and memory models, randomized blocks and
// backpressure, and a scoreboard queue checked by an independent monitor.
module tb_agu_rd;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned RL    = 2;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          agu_start, agu_en, agu_last;
  logic [AW-1:0] agu_data;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          m_valid, m_last, m_ready;
  logic [DW-1:0] m_data;
  logic          busy, done;
  logic [AW-1:0] beat_cnt;

  agu_rd #(.AW(AW), .DW(DW), .RL(RL), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .agu_start_o (agu_start),
    .agu_en_o    (agu_en),
    .agu_data_i  (agu_data),
    .agu_last_i  (agu_last),
    .mem_en_o    (mem_en),
    .mem_addr_o  (mem_addr),
    .mem_rdata_i (mem_rdata),
    .m_valid_o   (m_valid),
    .m_data_o    (m_data),
    .m_last_o    (m_last),
    .m_ready_i   (m_ready),
    .busy_o      (busy),
    .done_o      (done),
    .beat_cnt_o  (beat_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return DW'(a * 32'd3);
  endfunction

  // AGU model: loads ini on start, advances on en, last when the address equals fin.
  logic [AW-1:0] ini_r, fin_r, agu_cnt_q;
  assign agu_data = agu_start ? ini_r : agu_cnt_q;
  assign agu_last = (agu_data == fin_r);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) agu_cnt_q <= '0;
    else if (agu_en) agu_cnt_q <= agu_data + 1;
  end

  // Memory model: data = addr*3 appearing RL cycles after the read enable.
  logic [DW-1:0] rd_pipe [RL];
  always @(posedge clk) begin
    for (int i = RL - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= mem_en ? memf(mem_addr) : 32'hDEAD_BEEF;
  end
  assign mem_rdata = rd_pipe[RL-1];

  // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
  int rmode = 0;
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;
  beat_t exp_q[$];

  int  issue_cnt = 0;
  int  pop_cnt = 0;
  int  done_cnt = 0;
  bit  seen_valid = 1'b0;
  int  first_cyc = 0;
  int  last_pop_cyc = 0;

  // Monitor: pops the scoreboard on every accepted beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_en) issue_cnt++;
      if (agu_start && busy) fail_now("agu_start_while_busy");
      if (m_valid && !seen_valid) begin
        seen_valid = 1'b1;
        first_cyc  = cyc;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_extra_beat");
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", m_data, e.data);
          chk("beat_last", m_last, e.last);
        end
        pop_cnt++;
        last_pop_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_with_last_accept", m_valid & m_ready & m_last, 1);
      end
    end
  end

  task automatic run_block(input logic [AW-1:0] ini, input int n, input int rm,
                           input bit pester, input bit chk_lat);
    int d0, start_cyc, timeout, exp_issues;
    rmode = (rm == 2) ? 2 : rmode;
    ini_r = ini;
    fin_r = ini + AW'(n) - 1;
    @(posedge clk);
    #1;
    rmode = rm;
    chk("idle_before_start", busy, 0);
    start      = 1'b1;
    start_cyc  = cyc;
    seen_valid = 1'b0;
    issue_cnt  = 0;
    d0         = done_cnt;
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.data = memf(ini + AW'(i));
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end
    #1 chk("agu_start_on_start", agu_start, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("beat_cnt_cleared", beat_cnt, 0);
    if (rm == 2) begin
      repeat (10) @(posedge clk);
      #1;
      exp_issues = (n < DEPTH) ? n : DEPTH;
      chk("issues_under_stall", issue_cnt, exp_issues);
      rmode = 0;
    end
    timeout = 0;
    while (timeout < 3000) begin
      @(posedge clk);
      #1;
      if (done_cnt != d0) break;
      if (pester) start = 1'($urandom_range(0, 1));
      timeout++;
    end
    start = 1'b0;
    if (timeout >= 3000) fail_now("timeout_waiting_done");
    chk("busy_low_after_done", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_stays_low", busy, 0);
    chk("single_done_pulse", done_cnt - d0, 1);
    chk("all_beats_delivered", exp_q.size(), 0);
`ifdef AGU_RD_BEAT_CNT_EN
    chk("beat_cnt_after_done", beat_cnt, AW'(n));
`else
    chk("beat_cnt_tied_zero", beat_cnt, 0);
`endif
    if (chk_lat) chk("first_valid_latency", first_cyc - start_cyc, RL + 1);
    if (rm == 0) chk("full_throughput", last_pop_cyc - first_cyc, n - 1);
    exp_q.delete();
  endtask

  task automatic reset_mid_block();
    int p0, timeout;
    rmode = 0;
    ini_r = 32'h40;
    fin_r = 32'h49;
    @(posedge clk);
    #1;
    start = 1'b1;
    p0 = pop_cnt;
    for (int i = 0; i < 10; i++) begin
      beat_t b;
      b.data = memf(32'h40 + AW'(i));
      b.last = (i == 9);
      exp_q.push_back(b);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    timeout = 0;
    while (pop_cnt < p0 + 3 && timeout < 100) begin
      @(negedge clk);
      timeout++;
    end
    if (timeout >= 100) fail_now("timeout_waiting_beats");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_agu_en", agu_en, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_done", done, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_beats_after_reset", m_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ini_r = '0;
    fin_r = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_agu_start", agu_start, 0);
    chk("reset_agu_en", agu_en, 0);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_beat_cnt", beat_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_block(32'h10, 4, 0, 1'b0, 1'b1);
    run_block(32'h10, 4, 2, 1'b0, 1'b1);
    run_block(32'h20, 8, 2, 1'b0, 1'b1);
    run_block(32'h7, 1, 0, 1'b0, 1'b1);
    run_block(32'h0, 8, 1, 1'b1, 1'b0);
    run_block(32'h0, 8, 0, 1'b1, 1'b1);
    reset_mid_block();
    run_block(32'h40, 10, 0, 1'b0, 1'b1);
    run_block(32'h0, 16, 1, 1'b0, 1'b0);
    run_block(32'hFFFF_FFFE, 5, 0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      run_block($urandom, int'($urandom_range(1, 20)), int'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
